// File: rtl/affine_seq.sv
// Micro-instruction sequencer driving the affine register file read/write ports.
// Optional AFFINE_SAT_EN: ADD/SUB/MUL saturate instead of wrapping.
`timescale 1ns/1ps

package affine_pkg;
  localparam int unsigned N = 16;
endpackage

module affine_seq
  import affine_pkg::*;
#(
  parameter int unsigned FRAC = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_valid_i,
  output logic                instr_ready_o,
  input  logic [2:0]          op_i,
  input  logic [2:0]          dst_i,
  input  logic [2:0]          sa_i,
  input  logic [2:0]          sb_i,
  input  logic signed [N-1:0] imm_i,
  output logic [2:0]          rs_addr_o,
  input  logic signed [N-1:0] rs_data_i,
  output logic [2:0]          rd_addr_o,
  output logic signed [N-1:0] wd_data_o,
  output logic                wdual_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned PW = 2 * N;

  localparam logic [2:0] ADDR_PARK = 3'd3;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_DUAL = 3'd6;

  localparam logic signed [PW-1:0] MAXV = {{(PW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EX, S_WB} state_t;

  state_t               r_state, w_state;
  logic [2:0]           r_op, r_dst, r_sa, r_sb;
  logic [2:0]           w_op, w_dst, w_sa, w_sb;
  logic signed [N-1:0]  r_imm, w_imm;
  logic signed [N-1:0]  r_a, r_b, w_a, w_b;
  logic                 w_ready, w_wdual, w_done, w_err;
  logic [2:0]           w_rs_addr, w_rd_addr;
  logic signed [N-1:0]  w_wd_data, w_res;
  logic                 w_single;
  logic signed [PW-1:0] w_sum, w_diff, w_prod, w_shr;

  // Addresses 0..4 are readable (3 reads as zero); 5..7 are illegal.
  function automatic logic src_ok(input logic [2:0] a);
    return a <= 3'd4;
  endfunction

  function automatic logic dst_ok(input logic [2:0] a);
    return (a == 3'd1) || (a == 3'd2) || (a == 3'd4);
  endfunction

  function automatic logic signed [N-1:0] fit(input logic signed [PW-1:0] v);
`ifdef AFFINE_SAT_EN
    if (v > MAXV)      return MAXV[N-1:0];
    else if (v < MINV) return MINV[N-1:0];
    else               return v[N-1:0];
`else
    return v[N-1:0];
`endif
  endfunction

  assign w_sum  = PW'(r_a) + PW'(r_b);
  assign w_diff = PW'(r_a) - PW'(r_b);
  assign w_prod = PW'(r_a) * PW'(r_b);
  assign w_shr  = w_prod >>> FRAC;

  // Next-state and registered-output logic.
  always_comb begin
    w_state   = r_state;
    w_op      = r_op;
    w_dst     = r_dst;
    w_sa      = r_sa;
    w_sb      = r_sb;
    w_imm     = r_imm;
    w_a       = r_a;
    w_b       = r_b;
    w_ready   = 1'b0;
    w_rs_addr = ADDR_PARK;
    w_rd_addr = ADDR_PARK;
    w_wd_data = wd_data_o;
    w_wdual   = 1'b0;
    w_done    = 1'b0;
    w_err     = err_o;
    w_res     = '0;
    w_single  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (instr_valid_i) begin
          w_op      = op_i;
          w_dst     = dst_i;
          w_sa      = sa_i;
          w_sb      = sb_i;
          w_imm     = imm_i;
          w_rs_addr = src_ok(sa_i) ? sa_i : ADDR_PARK;
          w_ready   = 1'b0;
          w_state   = S_RDA;
        end
      end
      S_RDA: begin
        w_a       = src_ok(r_sa) ? rs_data_i : '0;
        w_err     = err_o | ~src_ok(r_sa);
        w_rs_addr = src_ok(r_sb) ? r_sb : ADDR_PARK;
        w_state   = S_RDB;
      end
      S_RDB: begin
        w_b     = src_ok(r_sb) ? rs_data_i : '0;
        w_err   = err_o | ~src_ok(r_sb);
        w_state = S_EX;
      end
      S_EX: begin
        case (r_op)
          OP_NOP:  w_res = '0;
          OP_MOV:  begin w_res = r_a;         w_single = 1'b1; end
          OP_ADD:  begin w_res = fit(w_sum);  w_single = 1'b1; end
          OP_SUB:  begin w_res = fit(w_diff); w_single = 1'b1; end
          OP_MUL:  begin w_res = fit(w_shr);  w_single = 1'b1; end
          OP_LDI:  begin w_res = r_imm;       w_single = 1'b1; end
          OP_DUAL: begin w_res = r_a;         w_wdual  = 1'b1; end
          default: w_err = 1'b1;
        endcase
        // Single writes to a non-writable target stay parked and flag an error.
        if (w_single) begin
          if (dst_ok(r_dst)) w_rd_addr = r_dst;
          else               w_err     = 1'b1;
        end
        w_wd_data = w_res;
        w_done    = 1'b1;
        w_state   = S_WB;
      end
      S_WB: begin
        w_ready = 1'b1;
        w_state = S_IDLE;
      end
      default: begin
        w_ready = 1'b1;
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_dst         <= '0;
      r_sa          <= '0;
      r_sb          <= '0;
      r_imm         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      instr_ready_o <= 1'b1;
      rs_addr_o     <= ADDR_PARK;
      rd_addr_o     <= ADDR_PARK;
      wd_data_o     <= '0;
      wdual_o       <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_op          <= w_op;
      r_dst         <= w_dst;
      r_sa          <= w_sa;
      r_sb          <= w_sb;
      r_imm         <= w_imm;
      r_a           <= w_a;
      r_b           <= w_b;
      instr_ready_o <= w_ready;
      rs_addr_o     <= w_rs_addr;
      rd_addr_o     <= w_rd_addr;
      wd_data_o     <= w_wd_data;
      wdual_o       <= w_wdual;
      done_o        <= w_done;
      err_o         <= w_err;
    end
  end

endmodule
